// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture buffer: records {pc, instr, x31} on every new pc,
// freezes on a pc self-loop (halt) or on stop, then drains oldest-first.
// Ports: clk, reset (async, active-low), arm, stop, pc, instr, x31,
//   rd_valid/rd_ready handshake with rd_pc, rd_instr, rd_x31 entry fields,
//   count, total, wrapped, halted and state status outputs.
// Optional macro TRACE_TIMESTAMP_EN adds rd_time and a per-entry cycle stamp.
module cpu_trace_buffer #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arm,
   input  logic                    stop,
   input  logic [XLEN-1:0]         pc,
   input  logic [XLEN-1:0]         instr,
   input  logic [XLEN-1:0]         x31,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [XLEN-1:0]         rd_pc,
   output logic [XLEN-1:0]         rd_instr,
   output logic [XLEN-1:0]         rd_x31,
`ifdef TRACE_TIMESTAMP_EN
   output logic [31:0]             rd_time,
`endif
   output logic [$clog2(DEPTH):0]  count,
   output logic [31:0]             total,
   output logic                    wrapped,
   output logic                    halted,
   output logic [1:0]              state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FROZEN  = 2'd2
   } state_t;

   state_t          st;
   logic            first;
   logic [XLEN-1:0] last_pc;
   logic [31:0]     stuck;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [XLEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_x31   [DEPTH];

   logic            cap;
   logic            qual;
   logic [31:0]     stuck_inc;
   logic            halt_hit;
   logic            full;
   logic            pop;

   assign state     = st;
   assign cap       = (st == CAPTURE);
   // the first capture cycle always records, even if pc matches stale last_pc
   assign qual      = cap && (first || (pc != last_pc));
   assign stuck_inc = stuck + 32'd1;
   assign halt_hit  = cap && !qual && (stuck_inc == 32'(HALT_CYCLES));
   assign full      = (count == CW'(DEPTH));
   assign pop       = rd_valid && rd_ready;

   assign rd_valid  = (st == FROZEN) && (count != '0);
   assign rd_pc     = rd_valid ? mem_pc[rd_ptr]    : '0;
   assign rd_instr  = rd_valid ? mem_instr[rd_ptr] : '0;
   assign rd_x31    = rd_valid ? mem_x31[rd_ptr]   : '0;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] tstamp;
   logic [31:0] mem_time [DEPTH];
   assign rd_time = rd_valid ? mem_time[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tstamp <= '0;
      else if (st == IDLE && arm)
         tstamp <= '0;
      else if (cap)
         tstamp <= tstamp + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (qual)
         mem_time[wr_ptr] <= tstamp;
   end
`endif

   // storage has no reset; contents are only visible through rd_valid
   always_ff @(posedge clk) begin
      if (qual) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= instr;
         mem_x31[wr_ptr]   <= x31;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st      <= IDLE;
         first   <= 1'b0;
         last_pc <= '0;
         stuck   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         total   <= '0;
         wrapped <= 1'b0;
         halted  <= 1'b0;
      end else begin
         unique case (st)
            IDLE: begin
               if (arm) begin
                  count   <= '0;
                  total   <= '0;
                  wrapped <= 1'b0;
                  halted  <= 1'b0;
                  wr_ptr  <= '0;
                  rd_ptr  <= '0;
                  stuck   <= '0;
                  first   <= 1'b1;
                  st      <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (qual) begin
                  wr_ptr  <= wr_ptr + AW'(1);
                  last_pc <= pc;
                  stuck   <= '0;
                  first   <= 1'b0;
                  if (total != '1)
                     total <= total + 32'd1;
                  // full: the write lands on the oldest slot
                  if (full) begin
                     rd_ptr  <= rd_ptr + AW'(1);
                     wrapped <= 1'b1;
                  end else begin
                     count <= count + CW'(1);
                  end
               end else begin
                  stuck <= stuck_inc;
               end
               if (halt_hit) begin
                  halted <= 1'b1;
                  st     <= FROZEN;
               end else if (stop) begin
                  st <= FROZEN;
               end
            end
            FROZEN: begin
               if (count == '0) begin
                  st <= IDLE;
               end else if (pop) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  count  <= count - CW'(1);
                  if (count == CW'(1))
                     st <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Non-intrusive commit-trace capture block for the single-cycle RISC-V CPU.
- Watches pc, the fetched instruction and x31 every clock, and records each new pc into a circular buffer of {pc, instr, x31}.
- Detects the self-loop halt idiom (pc stuck) and freezes itself automatically.
- Once frozen, the trace is drained in order through a valid/ready port, so a test harness or debug link can read the last DEPTH commits without fixed-time waits.

Parameters:
- XLEN, 32, width of pc, instr and x31 fields.
- DEPTH, 16, trace entries (power of two, >=2).
- HALT_CYCLES, 4, consecutive cycles of unchanged pc that declare a halt (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse: clear the buffer and start capture (honoured in IDLE only).
- stop  in  1  force freeze (honoured in CAPTURE only).
- pc  in  XLEN  CPU program counter.
- instr  in  XLEN  instruction at pc.
- x31  in  XLEN  current x31 value.
- rd_valid  out  1  oldest entry presented.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc, rd_instr, rd_x31  out  XLEN each  oldest entry fields.
- count  out  $clog2(DEPTH)+1  valid entries held.
- total  out  32  commits seen since arm, saturating at 2^32-1.
- wrapped  out  1  at least one entry overwritten since arm.
- halted  out  1  freeze was caused by halt detection.
- state  out  2  IDLE=0, CAPTURE=1, FROZEN=2.

Behaviour:
- Reset (reset=0, async): state=IDLE; count, total, wrapped, halted, rd_valid, rd_* all 0; pointers and stuck counter 0. Buffer contents are don't-care. Reset mid-capture or mid-drain abandons everything.
- IDLE: no capture. On arm: clear count, total, wrapped, halted, pointers; next state CAPTURE.
- CAPTURE, first cycle: always writes an entry; last_pc<=pc; stuck counter=0.
- CAPTURE, later cycles:
  - pc!=last_pc: write entry, last_pc<=pc, stuck counter=0.
  - pc==last_pc: no write, stuck counter+1.
  - When the counter reaches HALT_CYCLES, the next state is FROZEN and halted=1 that same edge.
- Write rules:
  - Entry = {pc, instr, x31} sampled that cycle; total+1 (saturating).
  - count<DEPTH: wr_ptr++, count++.
  - count==DEPTH: overwrite oldest, wr_ptr++, rd_ptr++, count unchanged, wrapped=1.
  - Pointers wrap modulo DEPTH.
- stop in CAPTURE: the entry for the current cycle is still written if it qualifies; next state FROZEN, halted=0. If stop and halt detection occur in the same cycle, halted=1.
- FROZEN:
  - rd_valid = (count!=0); rd_* = entry at rd_ptr, combinational from buffer.
  - rd_* must stay stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: rd_ptr++, count--.
  - When count becomes 0 (or is 0 on entry), next state IDLE.
  - total, wrapped and halted are held until the next arm.
- arm is ignored in CAPTURE and FROZEN. stop is ignored outside CAPTURE. rd_ready is ignored outside FROZEN.
- No capture in FROZEN; pc/instr/x31 are don't-care there.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- Defined:
  - Adds output rd_time (32) and a free-running 32-bit cycle counter, cleared on arm, incrementing every cycle in CAPTURE.
  - Each entry stores the counter value at write.
  - rd_time follows the same rd_* stability rules.
- Undefined: no counter, no port, no extra storage.

Test Plan:
- Basic halt (DEPTH=4, HALT_CYCLES=3):
  - Stimulus: arm; pc 0,4,8,12,12,12,12.
  - Response: FROZEN after the 4th 12; count=4, total=4, halted=1, wrapped=0.
  - Drain with rd_ready=1 yields pc 0,4,8,12 in order, then state IDLE.
- Wrap:
  - Stimulus: arm; pc 0,4,...,24 then hold 24.
  - Response: total=7, wrapped=1, count=4; drain yields 12,16,20,24.
- Back-pressure:
  - Stimulus: in FROZEN with 2 entries, rd_ready=0 for 5 cycles.
  - Response: rd_valid=1, rd_pc constant, count=2; then rd_ready=1 for 2 cycles empties the buffer, rd_valid=0, state=IDLE.
- Manual stop:
  - Stimulus: arm; pc 0,4; stop asserted with pc=8.
  - Response: entries 0,4,8 captured; halted=0; state=FROZEN.
- Illegal controls:
  - arm during CAPTURE: buffer unaffected.
  - stop in IDLE: state remains IDLE.
- Async reset: assert reset=0 mid-drain, off-clock-edge → state, count, rd_valid and total go to 0 immediately; no entries drain after release.
